// File: rtl/retire_commit_if.sv
// retire_commit_if
// Bundles the retire-bus signals between the ROB head / memory / front end
// (master side) and the commit stage (slave side).
//   Head:      ret_valid, ret_spec_valid, ret_rd_tag, ret_rd_reg, ret_data,
//              ret_store_data, ret_is_store, ret_is_branch, ret_pc,
//              ret_br_taken, ret_br_pred, ret_br_target
//   Pop:       retire_ack
//   ARF write: arf_wen, arf_waddr, arf_wdata
//   RST clear: rst_clr_en, rst_clr_reg, rst_clr_tag
//   Store:     mem_wr, mem_addr, mem_wdata, mem_ack
//   Predictor: bp_upd, bp_pc, bp_taken
//   Front end: flush, redirect_pc
//   Counters:  retired_cnt, flush_cnt (only with RETIRE_PERF_CNT_EN)
interface retire_commit_if #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
);
    logic             ret_valid;
    logic             ret_spec_valid;
    logic [TAG_W-1:0] ret_rd_tag;
    logic [4:0]       ret_rd_reg;
    logic [XLEN-1:0]  ret_data;
    logic [XLEN-1:0]  ret_store_data;
    logic             ret_is_store;
    logic             ret_is_branch;
    logic [XLEN-1:0]  ret_pc;
    logic             ret_br_taken;
    logic             ret_br_pred;
    logic [XLEN-1:0]  ret_br_target;
    logic             retire_ack;
    logic             arf_wen;
    logic [4:0]       arf_waddr;
    logic [XLEN-1:0]  arf_wdata;
    logic             rst_clr_en;
    logic [4:0]       rst_clr_reg;
    logic [TAG_W-1:0] rst_clr_tag;
    logic             mem_wr;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic             mem_ack;
    logic             bp_upd;
    logic [XLEN-1:0]  bp_pc;
    logic             bp_taken;
    logic             flush;
    logic [XLEN-1:0]  redirect_pc;
`ifdef RETIRE_PERF_CNT_EN
    logic [31:0]      retired_cnt;
    logic [15:0]      flush_cnt;
`endif

    modport master (
`ifdef RETIRE_PERF_CNT_EN
        input  retired_cnt, flush_cnt,
`endif
        output ret_valid, ret_spec_valid, ret_rd_tag, ret_rd_reg, ret_data,
        output ret_store_data, ret_is_store, ret_is_branch, ret_pc,
        output ret_br_taken, ret_br_pred, ret_br_target, mem_ack,
        input  retire_ack, arf_wen, arf_waddr, arf_wdata,
        input  rst_clr_en, rst_clr_reg, rst_clr_tag,
        input  mem_wr, mem_addr, mem_wdata,
        input  bp_upd, bp_pc, bp_taken, flush, redirect_pc
    );

    modport slave (
`ifdef RETIRE_PERF_CNT_EN
        output retired_cnt, flush_cnt,
`endif
        input  ret_valid, ret_spec_valid, ret_rd_tag, ret_rd_reg, ret_data,
        input  ret_store_data, ret_is_store, ret_is_branch, ret_pc,
        input  ret_br_taken, ret_br_pred, ret_br_target, mem_ack,
        output retire_ack, arf_wen, arf_waddr, arf_wdata,
        output rst_clr_en, rst_clr_reg, rst_clr_tag,
        output mem_wr, mem_addr, mem_wdata,
        output bp_upd, bp_pc, bp_taken, flush, redirect_pc
    );
endinterface

// File: rtl/retire_commit.sv
// retire_commit
// Commit stage at the consumer end of the retire bus. Pops the ROB head with
// a combinational acknowledge once its result is written, then issues the
// registered ARF write / status clear / predictor update one cycle later.
// Stores are sent through a req/ack handshake before they are popped;
// mispredicted branches produce a registered one-cycle flush and redirect.
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset
//   bus    - retire_commit_if.slave (head, ARF, RST, memory, predictor,
//            front-end signals)
// Optional feature macro: RETIRE_PERF_CNT_EN adds retired/flush counters.
module retire_commit #(
    parameter int TAG_W = 6,
    parameter int XLEN  = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    retire_commit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    logic             head_ready_s;
    logic             mispredict_s;
    logic             ack_s;
    logic             take_head_s;
    logic             store_start_s;

    logic             arf_wen_r;
    logic [4:0]       arf_waddr_r;
    logic [XLEN-1:0]  arf_wdata_r;
    logic             rst_clr_en_r;
    logic [4:0]       rst_clr_reg_r;
    logic [TAG_W-1:0] rst_clr_tag_r;
    logic             mem_wr_r;
    logic [XLEN-1:0]  mem_addr_r;
    logic [XLEN-1:0]  mem_wdata_r;
    logic             bp_upd_r;
    logic [XLEN-1:0]  bp_pc_r;
    logic             bp_taken_r;
    logic             flush_r;
    logic [XLEN-1:0]  redirect_pc_r;

    assign head_ready_s = bus.ret_valid & bus.ret_spec_valid;
    assign mispredict_s = bus.ret_br_taken ^ bus.ret_br_pred;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (head_ready_s && bus.ret_is_store) begin
                    state_next_s = ST_REQ;
                end else if (head_ready_s && bus.ret_is_branch && mispredict_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: state_next_s = IDLE;
            FLUSH:   state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode: head pop and commit/store-launch strobes
    always_comb begin
        ack_s         = 1'b0;
        take_head_s   = 1'b0;
        store_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (head_ready_s && !bus.ret_is_store) begin
                    ack_s       = 1'b1;
                    take_head_s = 1'b1;
                end else if (head_ready_s) begin
                    store_start_s = 1'b1;
                end else begin
                    ack_s = 1'b0;
                end
            end
            // The store entry is popped only after memory accepted it
            ST_DONE: ack_s = 1'b1;
            default: ack_s = 1'b0;
        endcase
    end

    // Commit register: one-cycle ARF / status / predictor / flush pulses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            arf_wen_r     <= 1'b0;
            arf_waddr_r   <= 5'd0;
            arf_wdata_r   <= {XLEN{1'b0}};
            rst_clr_en_r  <= 1'b0;
            rst_clr_reg_r <= 5'd0;
            rst_clr_tag_r <= {TAG_W{1'b0}};
            bp_upd_r      <= 1'b0;
            bp_pc_r       <= {XLEN{1'b0}};
            bp_taken_r    <= 1'b0;
            flush_r       <= 1'b0;
            redirect_pc_r <= {XLEN{1'b0}};
        end else begin
            // x0 is hardwired; its status entry is still cleared
            arf_wen_r    <= take_head_s && !bus.ret_is_branch && (bus.ret_rd_reg != 5'd0);
            rst_clr_en_r <= take_head_s && !bus.ret_is_branch;
            bp_upd_r     <= take_head_s && bus.ret_is_branch;
            flush_r      <= take_head_s && bus.ret_is_branch && mispredict_s;
            if (take_head_s) begin
                arf_waddr_r   <= bus.ret_rd_reg;
                arf_wdata_r   <= bus.ret_data;
                rst_clr_reg_r <= bus.ret_rd_reg;
                rst_clr_tag_r <= bus.ret_rd_tag;
                bp_pc_r       <= bus.ret_pc;
                bp_taken_r    <= bus.ret_br_taken;
                redirect_pc_r <= bus.ret_br_taken ? bus.ret_br_target
                                 : (bus.ret_pc + {{(XLEN-3){1'b0}}, 3'd4});
            end else begin
                arf_waddr_r   <= arf_waddr_r;
                arf_wdata_r   <= arf_wdata_r;
                rst_clr_reg_r <= rst_clr_reg_r;
                rst_clr_tag_r <= rst_clr_tag_r;
                bp_pc_r       <= bp_pc_r;
                bp_taken_r    <= bp_taken_r;
                redirect_pc_r <= redirect_pc_r;
            end
        end
    end

    // Store request: latch address/data at launch, hold until accepted
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {XLEN{1'b0}};
            mem_wdata_r <= {XLEN{1'b0}};
        end else if (store_start_s) begin
            mem_wr_r    <= 1'b1;
            mem_addr_r  <= bus.ret_data;
            mem_wdata_r <= bus.ret_store_data;
        end else if ((state_r == ST_REQ) && bus.mem_ack) begin
            mem_wr_r    <= 1'b0;
        end else begin
            mem_wr_r    <= mem_wr_r;
        end
    end

    assign bus.retire_ack  = ack_s;
    assign bus.arf_wen     = arf_wen_r;
    assign bus.arf_waddr   = arf_waddr_r;
    assign bus.arf_wdata   = arf_wdata_r;
    assign bus.rst_clr_en  = rst_clr_en_r;
    assign bus.rst_clr_reg = rst_clr_reg_r;
    assign bus.rst_clr_tag = rst_clr_tag_r;
    assign bus.mem_wr      = mem_wr_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.bp_upd      = bp_upd_r;
    assign bus.bp_pc       = bp_pc_r;
    assign bus.bp_taken    = bp_taken_r;
    assign bus.flush       = flush_r;
    assign bus.redirect_pc = redirect_pc_r;

`ifdef RETIRE_PERF_CNT_EN
    logic [31:0] retired_cnt_r;
    logic [15:0] flush_cnt_r;

    // Performance counters, free-running with natural wrap
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            retired_cnt_r <= 32'd0;
            flush_cnt_r   <= 16'd0;
        end else begin
            if (ack_s) begin
                retired_cnt_r <= retired_cnt_r + 32'd1;
            end else begin
                retired_cnt_r <= retired_cnt_r;
            end
            if (flush_r) begin
                flush_cnt_r <= flush_cnt_r + 16'd1;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign bus.retired_cnt = retired_cnt_r;
    assign bus.flush_cnt   = flush_cnt_r;
`endif

endmodule
